dma_scheduler: RTL and testbench

//  Two-channel DMA scheduler in front of the QBUS bus-master block. Each channel posts a block

---
 rtl/dma_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_dma_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_scheduler.sv
// Two-channel round-robin DMA scheduler that splits block transfers into single-word QBUS DATI/DATO cycles.
// Define DMA_BURST_EN to let the served channel keep the master for up to BURST_LEN consecutive words.
module dma_scheduler #(
   parameter int BURST_LEN = 4
) (
   input  logic        qclk,
   input  logic        reset_n,
   input  logic        ch0_start,
   input  logic [21:0] ch0_addr,
   input  logic [15:0] ch0_count,
   input  logic        ch0_write,
   input  logic [15:0] ch0_wdata,
   output logic        ch0_wack,
   output logic        ch0_rvalid,
   output logic        ch0_busy,
   output logic        ch0_done,
   output logic        ch0_err,
   input  logic        ch1_start,
   input  logic [21:0] ch1_addr,
   input  logic [15:0] ch1_count,
   input  logic        ch1_write,
   input  logic [15:0] ch1_wdata,
   output logic        ch1_wack,
   output logic        ch1_rvalid,
   output logic        ch1_busy,
   output logic        ch1_done,
   output logic        ch1_err,
   output logic [15:0] rdata,
   output logic        dma_read,
   output logic        dma_write,
   output logic [21:0] dma_addr,
   output logic [15:0] dma_wdata,
   input  logic [15:0] bus_rdata,
   input  logic        dma_complete,
   input  logic        nxm
);

   localparam int CW = $clog2(BURST_LEN + 1);
`ifdef DMA_BURST_EN
   localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);
`else
   localparam logic [CW-1:0] BURST_MAX = CW'(1);
`endif

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER} state_t;

   state_t        state_q, state_d;
   logic [1:0]    busy_q, busy_d;
   logic [1:0]    err_q, err_d;
   logic [1:0]    write_q, write_d;
   logic [1:0]    done_q, done_d;
   logic [1:0]    wack_q, wack_d;
   logic [1:0]    rvalid_q, rvalid_d;
   logic [21:0]   addr_q [2];
   logic [21:0]   addr_d [2];
   logic [15:0]   count_q [2];
   logic [15:0]   count_d [2];
   logic          dma_read_q, dma_read_d;
   logic          dma_write_q, dma_write_d;
   logic [21:0]   dma_addr_q, dma_addr_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          cur_q, cur_d;
   logic          last_q, last_d;
   logic [CW-1:0] burst_q, burst_d;
   logic          sel;

   logic [1:0]    start_w;
   logic [1:0]    write_in;
   logic [21:0]   addr_in [2];
   logic [15:0]   count_in [2];

   assign start_w     = {ch1_start, ch0_start};
   assign write_in    = {ch1_write, ch0_write};
   assign addr_in[0]  = ch0_addr & 22'h3FFFFE;
   assign addr_in[1]  = ch1_addr & 22'h3FFFFE;
   assign count_in[0] = ch0_count;
   assign count_in[1] = ch1_count;

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      err_d       = err_q;
      write_d     = write_q;
      addr_d      = addr_q;
      count_d     = count_q;
      done_d      = 2'b00;
      wack_d      = 2'b00;
      rvalid_d    = 2'b00;
      dma_read_d  = dma_read_q;
      dma_write_d = dma_write_q;
      dma_addr_d  = dma_addr_q;
      rdata_d     = rdata_q;
      cur_d       = cur_q;
      last_d      = last_q;
      burst_d     = burst_q;
      sel         = last_q;

      // A finished word or an aborted transfer releases the master this cycle.
      if (state_q == S_XFER && dma_complete) begin
         dma_read_d  = 1'b0;
         dma_write_d = 1'b0;
         if (nxm) begin
            err_d[cur_q]  = 1'b1;
            done_d[cur_q] = 1'b1;
            busy_d[cur_q] = 1'b0;
            burst_d       = BURST_MAX;
         end else begin
            if (write_q[cur_q]) begin
               wack_d[cur_q] = 1'b1;
            end else begin
               rvalid_d[cur_q] = 1'b1;
               rdata_d         = bus_rdata;
            end
            addr_d[cur_q]  = addr_q[cur_q] + 22'd2;
            count_d[cur_q] = count_q[cur_q] - 16'd1;
            if (count_q[cur_q] == 16'd1) begin
               done_d[cur_q] = 1'b1;
               busy_d[cur_q] = 1'b0;
               burst_d       = BURST_MAX;
            end
         end
      end

      // Keep the last channel while its burst allowance lasts, otherwise hand over.
      if (state_q == S_ARB && busy_q != 2'b00) begin
         if (busy_q == 2'b11) begin
            sel = (burst_q < BURST_MAX) ? last_q : ~last_q;
         end else begin
            sel = busy_q[1];
         end
         dma_addr_d  = addr_q[sel];
         dma_read_d  = ~write_q[sel];
         dma_write_d = write_q[sel];
         cur_d       = sel;
         last_d      = sel;
         burst_d     = (sel == last_q && burst_q < BURST_MAX) ? burst_q + 1'b1 : CW'(1);
      end

      // A channel that just finished may take a new request in the same cycle.
      for (int i = 0; i < 2; i++) begin
         if (start_w[i] && !busy_d[i]) begin
            addr_d[i]  = addr_in[i];
            count_d[i] = count_in[i];
            write_d[i] = write_in[i];
            err_d[i]   = 1'b0;
            if (count_in[i] == 16'd0) begin
               done_d[i] = 1'b1;
               busy_d[i] = 1'b0;
            end else begin
               busy_d[i] = 1'b1;
            end
         end
      end

      case (state_q)
         S_IDLE:  if (busy_d != 2'b00) state_d = S_ARB;
         S_ARB:   state_d = (busy_q != 2'b00) ? S_XFER : S_IDLE;
         S_XFER:  if (dma_complete) state_d = (busy_d != 2'b00) ? S_ARB : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge qclk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         busy_q      <= 2'b00;
         err_q       <= 2'b00;
         write_q     <= 2'b00;
         done_q      <= 2'b00;
         wack_q      <= 2'b00;
         rvalid_q    <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            addr_q[i]  <= 22'd0;
            count_q[i] <= 16'd0;
         end
         dma_read_q  <= 1'b0;
         dma_write_q <= 1'b0;
         dma_addr_q  <= 22'd0;
         rdata_q     <= 16'd0;
         cur_q       <= 1'b0;
         last_q      <= 1'b1;
         burst_q     <= BURST_MAX;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         write_q     <= write_d;
         done_q      <= done_d;
         wack_q      <= wack_d;
         rvalid_q    <= rvalid_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         dma_read_q  <= dma_read_d;
         dma_write_q <= dma_write_d;
         dma_addr_q  <= dma_addr_d;
         rdata_q     <= rdata_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         burst_q     <= burst_d;
      end
   end

   assign ch0_wack   = wack_q[0];
   assign ch1_wack   = wack_q[1];
   assign ch0_rvalid = rvalid_q[0];
   assign ch1_rvalid = rvalid_q[1];
   assign ch0_busy   = busy_q[0];
   assign ch1_busy   = busy_q[1];
   assign ch0_done   = done_q[0];
   assign ch1_done   = done_q[1];
   assign ch0_err    = err_q[0];
   assign ch1_err    = err_q[1];
   assign rdata      = rdata_q;
   assign dma_read   = dma_read_q;
   assign dma_write  = dma_write_q;
   assign dma_addr   = dma_addr_q;
   // The device holds its word until wack, so DATO data is taken straight from the served channel.
   assign dma_wdata  = dma_write_q ? (cur_q ? ch1_wdata : ch0_wdata) : 16'h0000;

endmodule

// File: tb/tb_dma_scheduler.sv
// Directed bench for dma_scheduler: table of single-channel transfers plus hand-written multi-cycle sequences.
module tb_dma_scheduler;

   logic        qclk = 1'b0;
   always #5 qclk = ~qclk;

   logic        reset_n;
   logic        ch0_start, ch0_write, ch1_start, ch1_write;
   logic [21:0] ch0_addr, ch1_addr;
   logic [15:0] ch0_count, ch1_count, ch0_wdata, ch1_wdata;
   logic        ch0_wack, ch0_rvalid, ch0_busy, ch0_done, ch0_err;
   logic        ch1_wack, ch1_rvalid, ch1_busy, ch1_done, ch1_err;
   logic [15:0] rdata, dma_wdata, bus_rdata;
   logic        dma_read, dma_write, dma_complete, nxm;
   logic [21:0] dma_addr;

   dma_scheduler dut (
      .qclk(qclk), .reset_n(reset_n),
      .ch0_start(ch0_start), .ch0_addr(ch0_addr), .ch0_count(ch0_count), .ch0_write(ch0_write),
      .ch0_wdata(ch0_wdata), .ch0_wack(ch0_wack), .ch0_rvalid(ch0_rvalid), .ch0_busy(ch0_busy),
      .ch0_done(ch0_done), .ch0_err(ch0_err),
      .ch1_start(ch1_start), .ch1_addr(ch1_addr), .ch1_count(ch1_count), .ch1_write(ch1_write),
      .ch1_wdata(ch1_wdata), .ch1_wack(ch1_wack), .ch1_rvalid(ch1_rvalid), .ch1_busy(ch1_busy),
      .ch1_done(ch1_done), .ch1_err(ch1_err),
      .rdata(rdata), .dma_read(dma_read), .dma_write(dma_write), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .bus_rdata(bus_rdata), .dma_complete(dma_complete), .nxm(nxm)
   );

   typedef struct {
      logic [21:0] a;
      logic        w;
      logic [15:0] d;
      logic        both;
   } cyc_t;

   typedef struct {
      logic [15:0] act;
      logic [15:0] exp;
   } rd_t;

   typedef struct {
      logic        ch;
      logic [21:0] addr;
      logic [15:0] count;
      logic        wr;
      int          nxm_at;
      int          exp_cyc;
      logic [21:0] exp_first;
      logic [21:0] exp_last;
      int          exp_ack;
      logic        exp_err;
      logic [15:0] exp_dlast;
   } vec_t;

   cyc_t        log_q[$];
   rd_t         rd_q[$];
   vec_t        vt[6];
   int          checks = 0, errors = 0;
   int          n_done0 = 0, n_done1 = 0, n_ack0 = 0, n_ack1 = 0, n_wk0 = 0, n_wk1 = 0;
   int          s_done0, s_done1, s_ack0, s_ack1, base, rd_idx = 0, lg_idx = 0;
   int          nxm_on = -1, wcnt = 0;
   bit          in_cyc = 0, stray = 0;
   logic [15:0] wbase0 = 16'h0, wbase1 = 16'h0, last_bus = 16'h0;
   logic        any_out;

   assign ch0_wdata = wbase0 + 16'(n_wk0);
   assign ch1_wdata = wbase1 + 16'(n_wk1);
   assign any_out = |{ch0_wack, ch0_rvalid, ch0_busy, ch0_done, ch0_err,
                      ch1_wack, ch1_rvalid, ch1_busy, ch1_done, ch1_err,
                      rdata, dma_read, dma_write, dma_addr, dma_wdata};

   // Bus-master model and output monitor: completes each cycle on its second sampled cycle.
   always @(negedge qclk) begin
      if (ch0_done) n_done0++;
      if (ch1_done) n_done1++;
      if (ch0_wack) begin n_ack0++; n_wk0++; end
      if (ch1_wack) begin n_ack1++; n_wk1++; end
      if (ch0_rvalid) begin n_ack0++; rd_q.push_back('{rdata, last_bus}); end
      if (ch1_rvalid) begin n_ack1++; rd_q.push_back('{rdata, last_bus}); end
      dma_complete = 1'b0;
      nxm          = 1'b0;
      if (!reset_n) begin
         in_cyc = 0;
      end else if (stray) begin
         dma_complete = 1'b1;
      end else if (dma_read || dma_write) begin
         if (!in_cyc) begin
            in_cyc = 1;
            wcnt   = 0;
            log_q.push_back('{dma_addr, dma_write, dma_wdata, dma_read & dma_write});
         end
         if (wcnt == 1) begin
            last_bus     = dma_addr[15:0] ^ 16'h5A5A;
            bus_rdata    = last_bus;
            dma_complete = 1'b1;
            nxm          = (log_q.size() == nxm_on);
         end
         wcnt++;
      end else begin
         in_cyc = 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end else begin
         $display("ok   %s value=0x%0h", nm, act);
      end
   endtask

   task automatic drain();
      while (rd_idx < rd_q.size()) begin
         chk("rdata", 32'(rd_q[rd_idx].act), 32'(rd_q[rd_idx].exp));
         rd_idx++;
      end
      while (lg_idx < log_q.size()) begin
         chk("rw_exclusive", 32'(log_q[lg_idx].both), 32'd0);
         lg_idx++;
      end
   endtask

   task automatic snap();
      s_done0 = n_done0; s_done1 = n_done1; s_ack0 = n_ack0; s_ack1 = n_ack1;
      base    = log_q.size();
   endtask

   task automatic start_ch(input logic ch, input logic [21:0] a, input logic [15:0] c, input logic w);
      @(negedge qclk);
      if (ch) begin ch1_start = 1'b1; ch1_addr = a; ch1_count = c; ch1_write = w; end
      else    begin ch0_start = 1'b1; ch0_addr = a; ch0_count = c; ch0_write = w; end
      @(negedge qclk);
      ch0_start = 1'b0;
      ch1_start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((ch0_busy || ch1_busy) && n < 400) begin
         @(negedge qclk);
         n++;
      end
      chk({nm, "_idle"}, 32'({ch1_busy, ch0_busy}), 32'd0);
      repeat (3) @(negedge qclk);
   endtask

   task automatic do_reset();
      @(negedge qclk);
      reset_n = 1'b0;
      repeat (2) @(negedge qclk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [21:0] exp_ord [4];
      int n;
      vt[0] = '{1'b0, 22'h001000, 16'd3, 1'b0, 0, 3, 22'h001000, 22'h001004, 3, 1'b0, 16'h0000};
      vt[1] = '{1'b0, 22'h3FFFFE, 16'd2, 1'b1, 0, 2, 22'h3FFFFE, 22'h000000, 2, 1'b0, 16'h1235};
      vt[2] = '{1'b1, 22'h000101, 16'd2, 1'b0, 0, 2, 22'h000100, 22'h000102, 2, 1'b0, 16'h0000};
      vt[3] = '{1'b1, 22'h200000, 16'd3, 1'b1, 2, 2, 22'h200000, 22'h200002, 1, 1'b1, 16'h1235};
      vt[4] = '{1'b1, 22'h000000, 16'd0, 1'b0, 0, 0, 22'h000000, 22'h000000, 0, 1'b0, 16'h0000};
      vt[5] = '{1'b0, 22'h0ABCDE, 16'd1, 1'b0, 0, 1, 22'h0ABCDE, 22'h0ABCDE, 1, 1'b0, 16'h0000};

      reset_n = 1'b0;
      ch0_start = 1'b0; ch0_addr = '0; ch0_count = '0; ch0_write = 1'b0;
      ch1_start = 1'b0; ch1_addr = '0; ch1_count = '0; ch1_write = 1'b0;
      repeat (3) @(negedge qclk);
      chk("reset_outputs", 32'(any_out), 32'd0);
      reset_n = 1'b1;

      // Latency: busy one edge after start, dma_read one edge later.
      snap();
      @(negedge qclk);
      ch0_start = 1'b1; ch0_addr = 22'h000040; ch0_count = 16'd1; ch0_write = 1'b0;
      @(negedge qclk);
      ch0_start = 1'b0;
      chk("lat_busy", 32'({ch0_busy, dma_read}), 32'h2);
      @(negedge qclk);
      chk("lat_dma_read", 32'(dma_read), 32'd1);
      chk("lat_dma_addr", 32'(dma_addr), 32'h40);
      wait_idle("lat");
      drain();

      for (int i = 0; i < 6; i++) begin
         snap();
         nxm_on = (vt[i].nxm_at > 0) ? base + vt[i].nxm_at : -1;
         wbase0 = 16'h1234 - 16'(n_wk0);
         wbase1 = 16'h1234 - 16'(n_wk1);
         start_ch(vt[i].ch, vt[i].addr, vt[i].count, vt[i].wr);
         wait_idle($sformatf("v%0d", i));
         chk($sformatf("v%0d_cycles", i), 32'(log_q.size() - base), 32'(vt[i].exp_cyc));
         if (vt[i].exp_cyc > 0 && log_q.size() >= base + vt[i].exp_cyc) begin
            chk($sformatf("v%0d_first", i), 32'(log_q[base].a), 32'(vt[i].exp_first));
            chk($sformatf("v%0d_last", i), 32'(log_q[base + vt[i].exp_cyc - 1].a), 32'(vt[i].exp_last));
            chk($sformatf("v%0d_dir", i), 32'(log_q[base].w), 32'(vt[i].wr));
            if (vt[i].wr) begin
               chk($sformatf("v%0d_wdata0", i), 32'(log_q[base].d), 32'h1234);
               chk($sformatf("v%0d_wdata_last", i), 32'(log_q[base + vt[i].exp_cyc - 1].d),
                   32'(vt[i].exp_dlast));
            end
         end
         chk($sformatf("v%0d_acks", i), 32'(vt[i].ch ? n_ack1 - s_ack1 : n_ack0 - s_ack0),
             32'(vt[i].exp_ack));
         chk($sformatf("v%0d_err", i), 32'(vt[i].ch ? ch1_err : ch0_err), 32'(vt[i].exp_err));
         chk($sformatf("v%0d_done", i), 32'({n_done1 - s_done1, n_done0 - s_done0}),
             vt[i].ch ? {32'd1, 32'd0} : {32'd0, 32'd1});
         drain();
      end
      nxm_on = -1;

      // Zero-count start: done on the next edge, no bus cycle; then start while busy is ignored.
      snap();
      @(negedge qclk);
      ch0_start = 1'b1; ch0_addr = 22'h000500; ch0_count = 16'd0; ch0_write = 1'b0;
      @(negedge qclk);
      ch0_start = 1'b0;
      chk("zero_done_pulse", 32'({ch0_done, ch0_busy}), 32'h2);
      @(negedge qclk);
      chk("zero_no_bus", 32'({ch0_done, dma_read, dma_write}), 32'd0);
      snap();
      start_ch(1'b0, 22'h001000, 16'd3, 1'b0);
      repeat (2) @(negedge qclk);
      ch0_start = 1'b1; ch0_addr = 22'h002000; ch0_count = 16'd5;
      @(negedge qclk);
      ch0_start = 1'b0;
      wait_idle("busy_start");
      chk("busy_start_cycles", 32'(log_q.size() - base), 32'd3);
      chk("busy_start_last", 32'(log_q[log_q.size() - 1].a), 32'h001004);
      chk("busy_start_done", 32'(n_done0 - s_done0), 32'd1);
      drain();

      // Both channels start together after reset.
      do_reset();
      snap();
      @(negedge qclk);
      ch0_start = 1'b1; ch0_addr = 22'h000010; ch0_count = 16'd2; ch0_write = 1'b0;
      ch1_start = 1'b1; ch1_addr = 22'h000020; ch1_count = 16'd2; ch1_write = 1'b0;
      @(negedge qclk);
      ch0_start = 1'b0; ch1_start = 1'b0;
      wait_idle("rr");
`ifdef DMA_BURST_EN
      exp_ord[0] = 22'h10; exp_ord[1] = 22'h12; exp_ord[2] = 22'h20; exp_ord[3] = 22'h22;
`else
      exp_ord[0] = 22'h10; exp_ord[1] = 22'h20; exp_ord[2] = 22'h12; exp_ord[3] = 22'h22;
`endif
      chk("rr_cycles", 32'(log_q.size() - base), 32'd4);
      n = (log_q.size() - base < 4) ? log_q.size() - base : 4;
      for (int k = 0; k < n; k++) chk($sformatf("rr_addr%0d", k), 32'(log_q[base + k].a), 32'(exp_ord[k]));
      chk("rr_done", 32'({n_done1 - s_done1, n_done0 - s_done0}), {32'd1, 32'd1});
      drain();

      // NXM on ch1's second word aborts ch1 only.
      do_reset();
      snap();
      nxm_on = base + 4;
      @(negedge qclk);
      ch0_start = 1'b1; ch0_addr = 22'h000010; ch0_count = 16'd2; ch0_write = 1'b0;
      ch1_start = 1'b1; ch1_addr = 22'h000020; ch1_count = 16'd4; ch1_write = 1'b0;
      @(negedge qclk);
      ch0_start = 1'b0; ch1_start = 1'b0;
      wait_idle("nxm");
      nxm_on = -1;
      chk("nxm_cycles", 32'(log_q.size() - base), 32'd4);
      chk("nxm_last_addr", 32'(log_q[log_q.size() - 1].a), 32'h22);
      chk("nxm_err", 32'({ch1_err, ch0_err}), 32'h2);
      chk("nxm_acks", 32'({n_ack1 - s_ack1, n_ack0 - s_ack0}), {32'd1, 32'd2});
      chk("nxm_done", 32'({n_done1 - s_done1, n_done0 - s_done0}), {32'd1, 32'd1});
      drain();

      // Stray dma_complete while idle is ignored.
      snap();
      @(negedge qclk);
      stray = 1'b1;
      @(negedge qclk);
      stray = 1'b0;
      repeat (3) @(negedge qclk);
      chk("stray_ignored", 32'({n_done0 - s_done0 + n_done1 - s_done1 + n_ack0 - s_ack0 + n_ack1 - s_ack1}),
          32'd0);
      chk("stray_busy", 32'({ch1_busy, ch0_busy, dma_read, dma_write}), 32'd0);

`ifdef DMA_BURST_EN
      begin
         logic [21:0] bo [12];
         bo = '{22'h100, 22'h102, 22'h104, 22'h106, 22'h200, 22'h202, 22'h204, 22'h206,
                22'h108, 22'h10A, 22'h208, 22'h20A};
         do_reset();
         snap();
         @(negedge qclk);
         ch0_start = 1'b1; ch0_addr = 22'h000100; ch0_count = 16'd6; ch0_write = 1'b0;
         ch1_start = 1'b1; ch1_addr = 22'h000200; ch1_count = 16'd6; ch1_write = 1'b0;
         @(negedge qclk);
         ch0_start = 1'b0; ch1_start = 1'b0;
         wait_idle("burst");
         chk("burst_cycles", 32'(log_q.size() - base), 32'd12);
         n = (log_q.size() - base < 12) ? log_q.size() - base : 12;
         for (int k = 0; k < n; k++) chk($sformatf("burst_addr%0d", k), 32'(log_q[base + k].a), 32'(bo[k]));
         drain();
      end
`endif

      // Reset during a DATO cycle clears every output on that edge.
      start_ch(1'b0, 22'h000300, 16'd4, 1'b1);
      n = 0;
      while (!dma_write && n < 50) begin
         @(negedge qclk);
         n++;
      end
      chk("midreset_active", 32'({ch0_busy, dma_write}), 32'h3);
      reset_n = 1'b0;
      @(negedge qclk);
      chk("midreset_outputs", 32'(any_out), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge qclk);
      chk("midreset_stays_idle", 32'({ch0_busy, dma_write, dma_read}), 32'd0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
